// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch side.
//   state_t         : loader FSM states
//   BYTES_PER_WORD  : bytes per instruction word
//   byte_lane()     : big-endian byte lane select (beat 0 -> bits [31:24])
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Beat 0 carries the most significant byte, so the byte at the word
    // address is bits [31:24]; the fetch side reassembles in the same order.
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  beat);
        logic [7:0] lane;
        case (beat)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bus bundle between a host/boot source, the loader and the instruction
// memory write port.
//   Control : start, base_addr, num_words -> busy, done, err, words_loaded
//   Stream  : word_data, word_valid -> word_ready
//   Memory  : mem_we, mem_addr, mem_wdata (byte write port)
// master = host side, slave = loader.
interface instr_mem_loader_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] num_words;
    logic [31:0]      word_data;
    logic             word_valid;
    logic             word_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] words_loaded;

    modport master (
        output start, base_addr, num_words, word_data, word_valid,
        input  word_ready, mem_we, mem_addr, mem_wdata,
               busy, done, err, words_loaded
    );

    modport slave (
        input  start, base_addr, num_words, word_data, word_valid,
        output word_ready, mem_we, mem_addr, mem_wdata,
               busy, done, err, words_loaded
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: takes 32-bit words from a valid/ready stream and writes
// each as four big-endian byte writes into the instruction memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_mem_loader_if.slave (control, word stream, mem port)
// Every output is decoded from registered state only.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int CNT_W     = 8
) (
    input logic               clk,
    input logic               rst_n,
    instr_mem_loader_if.slave bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_ptr;
    logic [31:0]      r_hold;
    logic [1:0]       r_beat;
    logic [CNT_W-1:0] r_num_words;
    logic [CNT_W-1:0] r_words_loaded;
    logic             r_err;

    logic             w_overflow;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_last_beat;
    logic [CNT_W-1:0] w_loaded_inc;

    // Widened by one bit so a pointer near 2^32 cannot wrap past the check.
    assign w_overflow   = ({1'b0, r_ptr} + 33'(BYTES_PER_WORD)) > 33'(MEM_BYTES);
    assign w_misaligned = (bus.base_addr[1:0] != 2'b00);
    assign w_accept     = (r_state == WAIT_WORD) && !w_overflow && bus.word_valid;
    assign w_last_beat  = (r_state == WRITE) && (r_beat == 2'd3);
    assign w_loaded_inc = r_words_loaded + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches
    // on paths that do not change state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_misaligned || (bus.num_words == '0)) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = WAIT_WORD;
                    end
                end
            end
            WAIT_WORD: begin
                if (w_overflow) begin
                    w_next_state = DONE;
                end else if (bus.word_valid) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                if (r_beat == 2'd3) begin
                    w_next_state = (w_loaded_inc == r_num_words) ? DONE : WAIT_WORD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= '0;
            r_hold         <= '0;
            r_beat         <= '0;
            r_num_words    <= '0;
            r_words_loaded <= '0;
            r_err          <= 1'b0;
        end else begin
            if ((r_state == IDLE) && bus.start) begin
                r_ptr          <= bus.base_addr;
                r_num_words    <= bus.num_words;
                r_words_loaded <= '0;
                r_err          <= w_misaligned;
            end
            if ((r_state == WAIT_WORD) && w_overflow) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_hold <= bus.word_data;
                r_beat <= 2'd0;
            end
            if (r_state == WRITE) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_last_beat) begin
                r_words_loaded <= w_loaded_inc;
                r_ptr          <= r_ptr + 32'(BYTES_PER_WORD);
            end
        end
    end

    assign bus.word_ready   = (r_state == WAIT_WORD) && !w_overflow;
    assign bus.mem_we       = (r_state == WRITE);
    assign bus.mem_addr     = bus.mem_we ? (r_ptr + 32'(r_beat)) : '0;
    assign bus.mem_wdata    = bus.mem_we ? byte_lane(r_hold, r_beat) : '0;
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = (r_state == DONE);
    assign bus.err          = r_err;
    assign bus.words_loaded = r_words_loaded;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader. Inputs change 1 time unit after
// the rising edge; outputs are compared at that point, away from the edge.
// A byte-array model captures every memory write on the rising edge.
module tb_instr_mem_loader;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tb_mem [0:127] = '{default: 8'h00};
    int         n_writes = 0;
    int         bad_addr = 0;
    int         base_writes;

    instr_mem_loader_if #(.CNT_W(8)) bus ();

    instr_mem_loader #(.MEM_BYTES(64), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            tb_mem[bus.mem_addr[6:0]] = bus.mem_wdata;
            n_writes = n_writes + 1;
            if (bus.mem_addr >= 32'd64) bad_addr = bad_addr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [31:0] base, input logic [7:0] n);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_words = n;
        tick();
        bus.start     = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {tb_mem[a], tb_mem[a+1], tb_mem[a+2], tb_mem[a+3]};
    endfunction

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.num_words  = '0;
        bus.word_data  = '0;
        bus.word_valid = 1'b0;

        // Reset values
        tick(2);
        check("rst_word_ready", bus.word_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_words_loaded", bus.words_loaded, 0);
        rst_n = 1'b1;
        tick();

        // Basic load, word_valid held high
        base_writes = n_writes;
        start_load(32'd0, 8'd2);
        check("basic_ready_t1", bus.word_ready, 1);
        check("basic_busy_t1", bus.busy, 1);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h8C010004;
        tick();                                  // h+1
        bus.word_data  = 32'h00221820;
        check("basic_we_h1", bus.mem_we, 1);
        check("basic_addr_h1", bus.mem_addr, 0);
        check("basic_data_h1", bus.mem_wdata, 32'h8C);
        check("basic_ready_h1", bus.word_ready, 0);
        tick(3);                                 // h+4
        check("basic_addr_h4", bus.mem_addr, 3);
        check("basic_data_h4", bus.mem_wdata, 32'h04);
        tick();                                  // h+5 second handshake
        check("basic_we_h5", bus.mem_we, 0);
        check("basic_ready_h5", bus.word_ready, 1);
        tick();                                  // h+6
        bus.word_valid = 1'b0;
        check("basic_addr_h6", bus.mem_addr, 4);
        tick(3);                                 // h+9
        check("basic_addr_h9", bus.mem_addr, 7);
        check("basic_data_h9", bus.mem_wdata, 32'h20);
        tick();                                  // h+10
        check("basic_done", bus.done, 1);
        check("basic_busy_done", bus.busy, 1);
        check("basic_words_loaded", bus.words_loaded, 2);
        check("basic_err", bus.err, 0);
        tick();
        check("basic_done_pulse", bus.done, 0);
        check("basic_idle", bus.busy, 0);
        check("basic_mem_w0", mem_word(0), 32'h8C010004);
        check("basic_mem_w1", mem_word(4), 32'h00221820);
        check("basic_nwrites", 32'(n_writes - base_writes), 8);

        // Backpressure: 3-cycle gap before the second word
        base_writes = n_writes;
        start_load(32'd0, 8'd2);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h11223344;
        tick();                                  // h+1
        bus.word_valid = 1'b0;
        tick(4);                                 // h+5
        for (int i = 0; i < 3; i++) begin
            check("bp_gap_we", bus.mem_we, 0);
            check("bp_gap_ready", bus.word_ready, 1);
            tick();
        end                                      // h+8
        check("bp_gap_nwrites", 32'(n_writes - base_writes), 4);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h55667788;
        tick();                                  // h+9
        bus.word_valid = 1'b0;
        check("bp_addr_h9", bus.mem_addr, 4);
        check("bp_data_h9", bus.mem_wdata, 32'h55);
        tick(3);                                 // h+12
        check("bp_addr_h12", bus.mem_addr, 7);
        check("bp_data_h12", bus.mem_wdata, 32'h88);
        tick();                                  // h+13
        check("bp_done_h13", bus.done, 1);
        check("bp_words_loaded", bus.words_loaded, 2);
        tick();
        check("bp_idle", bus.busy, 0);
        check("bp_mem_w1", mem_word(4), 32'h55667788);
        check("bp_nwrites", 32'(n_writes - base_writes), 8);

        // Overflow: base 56, three words requested, only two fit
        base_writes = n_writes;
        start_load(32'd56, 8'd3);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hA1A2A3A4;
        tick();                                  // h+1
        bus.word_data  = 32'hB1B2B3B4;
        tick(8);                                 // h+9
        check("ovf_addr_h9", bus.mem_addr, 63);
        tick();                                  // h+10
        check("ovf_ready_blocked", bus.word_ready, 0);
        check("ovf_we_h10", bus.mem_we, 0);
        tick();                                  // h+11
        bus.word_valid = 1'b0;
        check("ovf_done", bus.done, 1);
        check("ovf_err", bus.err, 1);
        check("ovf_words_loaded", bus.words_loaded, 2);
        tick();
        check("ovf_idle", bus.busy, 0);
        check("ovf_err_sticky", bus.err, 1);
        check("ovf_mem_w0", mem_word(56), 32'hA1A2A3A4);
        check("ovf_mem_w1", mem_word(60), 32'hB1B2B3B4);
        check("ovf_nwrites", 32'(n_writes - base_writes), 8);
        check("ovf_bad_addr", 32'(bad_addr), 0);

        // Misaligned base
        base_writes = n_writes;
        start_load(32'd2, 8'd1);
        check("mis_done", bus.done, 1);
        check("mis_err", bus.err, 1);
        check("mis_ready", bus.word_ready, 0);
        tick();
        check("mis_idle", bus.busy, 0);
        check("mis_nwrites", 32'(n_writes - base_writes), 0);

        // Zero-length load clears err
        start_load(32'd0, 8'd0);
        check("zero_done", bus.done, 1);
        check("zero_err", bus.err, 0);
        tick();
        check("zero_done_pulse", bus.done, 0);
        check("zero_idle", bus.busy, 0);
        check("zero_nwrites", 32'(n_writes - base_writes), 0);

        // Reset during beat 2 of the second word
        base_writes = n_writes;
        start_load(32'd16, 8'd2);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hC0C1C2C3;
        tick();                                  // h+1
        bus.word_data  = 32'hD0D1D2D3;
        tick(5);                                 // h+6
        bus.word_valid = 1'b0;
        tick(2);                                 // h+8, beat 2
        check("rmid_addr", bus.mem_addr, 22);
        check("rmid_words_loaded", bus.words_loaded, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_we", bus.mem_we, 0);
        check("rmid_busy", bus.busy, 0);
        check("rmid_words_cleared", bus.words_loaded, 0);
        tick(2);
        check("rmid_nwrites", 32'(n_writes - base_writes), 6);
        check("rmid_mem_w0", mem_word(16), 32'hC0C1C2C3);
        check("rmid_mem_partial", mem_word(20), 32'hD0D10000);
        rst_n = 1'b1;
        tick();
        check("rmid_idle_busy", bus.busy, 0);
        check("rmid_idle_ready", bus.word_ready, 0);
        start_load(32'd24, 8'd1);
        check("rmid_restart_ready", bus.word_ready, 1);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hE0E1E2E3;
        tick();
        bus.word_valid = 1'b0;
        tick(4);
        check("rmid_restart_done", bus.done, 1);
        check("rmid_restart_words", bus.words_loaded, 1);
        tick();
        check("rmid_restart_mem", mem_word(24), 32'hE0E1E2E3);

        // Start while busy and start coinciding with done are both ignored
        base_writes = n_writes;
        start_load(32'd32, 8'd1);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hF0F1F2F3;
        tick();                                  // h+1
        bus.word_valid = 1'b0;
        start_load(32'd40, 8'd5);                // pulse in WRITE, h+2
        check("ign_addr_h2", bus.mem_addr, 33);
        tick(2);                                 // h+4
        check("ign_addr_h4", bus.mem_addr, 35);
        tick();                                  // h+5
        check("ign_done", bus.done, 1);
        check("ign_words_loaded", bus.words_loaded, 1);
        start_load(32'd44, 8'd1);                // start during DONE
        check("ign_done_start_idle", bus.busy, 0);
        check("ign_done_start_ready", bus.word_ready, 0);
        tick();
        check("ign_still_idle", bus.busy, 0);
        check("ign_mem", mem_word(32), 32'hF0F1F2F3);
        check("ign_nwrites", 32'(n_writes - base_writes), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
